lif_array_sched: RTL

Time-multiplexed scheduler that shares one LIF neuron update datapath among `N_NEURONS` virtual neurons. Per-neuron membrane state, threshold and decay rate live in local register arrays. On each `start` the scheduler walks neurons 0..N-1 in order: it accepts one input current per neuron, applies one LIF update, and emits a spike event for every neuron that fires. It sits between the input-current source and the spike-event consumer in the demo neuron array.

---
 rtl/lif_pkg.sv | 28 ++
 rtl/lif_update.sv | 43 ++++
 rtl/lif_array_sched.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/lif_pkg.sv
// Shared constants, FSM encoding and fixed-point helper for the LIF neuron array.
package lif_pkg;

    localparam int unsigned DW        = 8;
    localparam int unsigned PW        = 17;
    localparam int unsigned ADAPT_INC = 295;
    localparam int unsigned ADAPT_DEC = 250;
    localparam int unsigned THR_MAX   = 220;
    localparam int unsigned THR_MIN   = 32;
    localparam int unsigned BETA_MIN  = 128;
    localparam int unsigned BETA_MAX  = 220;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_UPDATE,
        S_EMIT,
        S_DONE
    } fsm_t;

    // (v * k) >> 8 evaluated at 17 bits, truncated to 8 bits
    function automatic logic [DW-1:0] scale8(input logic [DW-1:0] v, input int unsigned k);
        logic [PW-1:0] p;
        p = PW'(v) * PW'(k);
        return DW'(p >> 8);
    endfunction

endpackage

// File: rtl/lif_update.sv
// Single-neuron LIF update: fire decision on the stored state, leak/integrate, adaptation.
module lif_update
    import lif_pkg::*;
(
    input  logic [DW-1:0] i_state,
    input  logic [DW-1:0] i_thr,
    input  logic [DW-1:0] i_beta,
    input  logic [DW-1:0] i_cur,
    input  logic          i_adapt_thr,
    input  logic          i_adapt_beta,
    output logic          o_fire,
    output logic [DW-1:0] o_state_n,
    output logic [DW-1:0] o_thr_n,
    output logic [DW-1:0] o_beta_n
);

    logic [DW-1:0] w_decay;
    logic [DW:0]   w_sum;

    assign w_decay = scale8(i_state, i_beta);
    assign w_sum   = (DW+1)'(i_cur) + (DW+1)'(w_decay);

    // Fire resets the membrane and tightens adaptation; otherwise integrate with saturation
    always_comb begin
        o_fire    = (i_state >= i_thr);
        o_state_n = '0;
        o_thr_n   = i_thr;
        o_beta_n  = i_beta;
        if (o_fire) begin
            if (i_adapt_thr && (i_thr < DW'(THR_MAX)))
                o_thr_n = scale8(i_thr, ADAPT_INC);
            if (i_adapt_beta && (i_beta > DW'(BETA_MIN)))
                o_beta_n = scale8(i_beta, ADAPT_DEC);
        end else begin
            o_state_n = w_sum[DW] ? {DW{1'b1}} : w_sum[DW-1:0];
            if (i_adapt_thr && (i_thr > DW'(THR_MIN)))
                o_thr_n = scale8(i_thr, ADAPT_DEC);
            if (i_adapt_beta && (i_beta < DW'(BETA_MAX)))
                o_beta_n = scale8(i_beta, ADAPT_INC);
        end
    end

endmodule

// File: rtl/lif_array_sched.sv
// Time-multiplexed scheduler sharing one LIF update datapath across N virtual neurons.
module lif_array_sched
    import lif_pkg::*;
#(
    parameter  int unsigned N_NEURONS   = 4,
    parameter  int unsigned THRESH_INIT = 100,
    parameter  int unsigned BETA_INIT   = 224,
    localparam int unsigned IW          = $clog2(N_NEURONS)
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          adaptive_threshold,
    input  logic          adaptive_beta,
    input  logic          cur_valid,
    input  logic [DW-1:0] cur_data,
    output logic          cur_ready,
    output logic [IW-1:0] cur_idx,
    output logic          spike_valid,
    output logic [IW-1:0] spike_id,
    input  logic          spike_ready,
    output logic          busy,
    output logic          done,
    input  logic [IW-1:0] mon_sel,
    output logic [DW-1:0] mon_state
);

    fsm_t          r_fsm;
    fsm_t          w_fsm_n;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] w_idx_n;
    logic [DW-1:0] r_cur;
    logic [DW-1:0] r_state [N_NEURONS];
    logic [DW-1:0] r_thr   [N_NEURONS];
    logic [DW-1:0] r_beta  [N_NEURONS];

    logic          w_fire;
    logic [DW-1:0] w_state_n;
    logic [DW-1:0] w_thr_n;
    logic [DW-1:0] w_beta_n;
    logic          w_last;

    assign w_last = (r_idx == IW'(N_NEURONS - 1));

    lif_update u_update (
        .i_state      (r_state[r_idx]),
        .i_thr        (r_thr[r_idx]),
        .i_beta       (r_beta[r_idx]),
        .i_cur        (r_cur),
        .i_adapt_thr  (adaptive_threshold),
        .i_adapt_beta (adaptive_beta),
        .o_fire       (w_fire),
        .o_state_n    (w_state_n),
        .o_thr_n      (w_thr_n),
        .o_beta_n     (w_beta_n)
    );

    // FSM state, neuron index and latched input current
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fsm <= S_IDLE;
            r_idx <= '0;
            r_cur <= '0;
        end else begin
            r_fsm <= w_fsm_n;
            r_idx <= w_idx_n;
            if ((r_fsm == S_FETCH) && cur_valid)
                r_cur <= cur_data;
        end
    end

    // Next-state logic; a completed neuron either wraps to DONE or advances idx
    always_comb begin
        w_fsm_n = r_fsm;
        w_idx_n = r_idx;
        case (r_fsm)
            S_IDLE: begin
                if (start) begin
                    w_fsm_n = S_FETCH;
                    w_idx_n = '0;
                end
            end
            S_FETCH: begin
                if (cur_valid)
                    w_fsm_n = S_UPDATE;
            end
            S_UPDATE: begin
                if (w_fire) begin
                    w_fsm_n = S_EMIT;
                end else if (w_last) begin
                    w_fsm_n = S_DONE;
                end else begin
                    w_fsm_n = S_FETCH;
                    w_idx_n = r_idx + IW'(1);
                end
            end
            S_EMIT: begin
                if (spike_ready) begin
                    if (w_last) begin
                        w_fsm_n = S_DONE;
                    end else begin
                        w_fsm_n = S_FETCH;
                        w_idx_n = r_idx + IW'(1);
                    end
                end
            end
            S_DONE: begin
                w_fsm_n = S_IDLE;
            end
            default: begin
                w_fsm_n = S_IDLE;
                w_idx_n = '0;
            end
        endcase
    end

    // Per-neuron membrane, threshold and decay storage; written back once per UPDATE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_NEURONS); i++) begin
                r_state[i] <= '0;
                r_thr[i]   <= DW'(THRESH_INIT);
                r_beta[i]  <= DW'(BETA_INIT);
            end
        end else if (r_fsm == S_UPDATE) begin
            r_state[r_idx] <= w_state_n;
            r_thr[r_idx]   <= w_thr_n;
            r_beta[r_idx]  <= w_beta_n;
        end
    end

    // Handshake and status outputs decoded from registered state only
    assign cur_ready   = (r_fsm == S_FETCH);
    assign cur_idx     = r_idx;
    assign spike_valid = (r_fsm == S_EMIT);
    assign spike_id    = r_idx;
    assign busy        = (r_fsm != S_IDLE);
    assign done        = (r_fsm == S_DONE);

    // Debug read port; out-of-range selects read as zero
    assign mon_state = (32'(mon_sel) < N_NEURONS) ? r_state[mon_sel] : '0;

endmodule
